mem_arbiter: RTL and testbench

- Shares one unified, single-ported, variable-latency memory between instruction fetch (F stage) and load/store (M stage) of the 5-stage pipeline.
- At most one memory transaction is outstanding at a time.
- Drives a single `mem_stall` that the hazard unit ORs into StallF/StallD/StallE/StallM/StallW.
- Holds returned data stable until the whole pipeline advances.

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the unified-memory arbiter.
// The state encoding is fixed so that traces stay readable across revisions.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_D = 2'd1,
        WAIT_I = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between fetch and load/store.
// Keeps one transaction in flight, raises a pipeline-wide stall, and has a watchdog that aborts a hung access.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_be,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_be,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_valid,
    output logic                  mem_stall,
    output logic                  err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic WD_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] LAST_CNT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    arb_state_t          r_state;
    logic                r_if_done;
    logic                r_dm_done;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_err;
    logic [CNT_W-1:0]    r_wait_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [BE_W-1:0]     r_mem_be;

    logic                w_if_pend;
    logic                w_dm_pend;
    logic                w_stall;
    logic                w_waiting;
    logic                w_timeout;
    logic                w_finish;

    assign w_if_pend = if_req & ~r_if_done;
    assign w_dm_pend = dm_req & ~r_dm_done;
    assign w_stall   = w_if_pend | w_dm_pend;
    assign w_waiting = (r_state == WAIT_D) || (r_state == WAIT_I);
    // A completion on the last permitted cycle wins over the abort.
    assign w_timeout = WD_EN & w_waiting & ~mem_valid & (r_wait_cnt == LAST_CNT);
    assign w_finish  = w_waiting & (mem_valid | w_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
            r_err       <= 1'b0;
            r_wait_cnt  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            // Done flags clear when the pipeline advances; a completion in the same cycle still sets them.
            if (!w_stall) begin
                r_if_done <= 1'b0;
                r_dm_done <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_wait_cnt <= '0;
                    if (w_dm_pend) begin
                        r_state     <= WAIT_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_mem_be    <= dm_be;
                    end else if (w_if_pend) begin
                        r_state     <= WAIT_I;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                        r_mem_be    <= '1;
                    end
                end
                WAIT_D, WAIT_I: begin
                    if (w_finish) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        if (r_state == WAIT_D) begin
                            r_dm_done <= 1'b1;
                            if (!r_mem_we) begin
                                r_dm_rdata <= mem_valid ? mem_rdata : '0;
                            end
                        end else begin
                            r_if_done  <= 1'b1;
                            r_if_rdata <= mem_valid ? mem_rdata : '0;
                        end
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign mem_stall = w_stall;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed instructions, a simple memory responder,
// and a transaction-level reference model compared against the DUT every cycle.
module tb_mem_arbiter;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = 32'hBAD0_BAD0;
    logic        mem_valid = 1'b0;
    logic        mem_stall;
    logic        err;

    int nChecks = 0;
    int nFail = 0;

    int respDelay = 0;
    bit respNever = 1'b0;
    bit injectStray = 1'b0;
    int rWait = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .mem_stall(mem_stall), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h0051_3023;
            32'h0000_0008: return 32'h0000_0013;
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0104: return 32'hCAFE_F00D;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: answers mem_valid on the (respDelay+1)-th wait cycle of each request.
    initial begin : responder
        forever begin
            @(posedge clk);
            #2;
            if (injectStray) begin
                mem_valid = 1'b1;
                mem_rdata = 32'h7777_7777;
                rWait = 0;
            end else if (mem_req) begin
                rWait++;
                if (!respNever && rWait == respDelay + 1) begin
                    mem_valid = 1'b1;
                    mem_rdata = memData(mem_addr);
                end else begin
                    mem_valid = 1'b0;
                    mem_rdata = 32'hBAD0_BAD0;
                end
            end else begin
                rWait = 0;
                mem_valid = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
            end
        end
    end

    // Reference model at transaction level: who is being served, what was served this instruction.
    int          mOwner = 0;
    int          mWaited = 0;
    bit          mServedI = 1'b0;
    bit          mServedD = 1'b0;
    bit          mErr = 1'b0;
    logic [31:0] mIf = '0;
    logic [31:0] mDm = '0;
    logic [31:0] mAddr = '0;
    logic [31:0] mWd = '0;
    logic [3:0]  mBe = '0;
    bit          mWe = 1'b0;

    function automatic bit modelStall();
        return (if_req && !mServedI) || (dm_req && !mServedD);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mOwner <= 0; mWaited <= 0; mServedI <= 1'b0; mServedD <= 1'b0; mErr <= 1'b0;
            mIf <= '0; mDm <= '0; mAddr <= '0; mWd <= '0; mBe <= '0; mWe <= 1'b0;
        end else begin
            if (!modelStall()) begin
                mServedI <= 1'b0;
                mServedD <= 1'b0;
            end
            if (mOwner == 0) begin
                mWaited <= 0;
                if (dm_req && !mServedD) begin
                    mOwner <= 1; mAddr <= dm_addr; mWe <= dm_we; mWd <= dm_wdata; mBe <= dm_be;
                end else if (if_req && !mServedI) begin
                    mOwner <= 2; mAddr <= if_addr; mWe <= 1'b0; mWd <= '0; mBe <= 4'hF;
                end
            end else if (mem_valid || (mWaited + 1 == TO)) begin
                if (mOwner == 1) begin
                    mServedD <= 1'b1;
                    if (!mWe) mDm <= mem_valid ? mem_rdata : 32'h0;
                end else begin
                    mServedI <= 1'b1;
                    mIf <= mem_valid ? mem_rdata : 32'h0;
                end
                if (!mem_valid) mErr <= 1'b1;
                mOwner <= 0;
            end else begin
                mWaited <= mWaited + 1;
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("mem_req", {31'b0, mem_req}, {31'b0, mOwner != 0});
        checkOutput("mem_stall", {31'b0, mem_stall}, {31'b0, modelStall()});
        checkOutput("if_rdata", if_rdata, mIf);
        checkOutput("dm_rdata", dm_rdata, mDm);
        checkOutput("err", {31'b0, err}, {31'b0, mErr});
        if (mOwner != 0) begin
            checkOutput("mem_addr", mem_addr, mAddr);
            checkOutput("mem_we", {31'b0, mem_we}, {31'b0, mWe});
            checkOutput("mem_be", {28'b0, mem_be}, {28'b0, mBe});
            if (mWe) checkOutput("mem_wdata", mem_wdata, mWd);
        end
    end

    // One pipeline instruction: hold requests until the first non-stalled cycle.
    task automatic applyStimulus(input bit ifOn, input logic [31:0] ifA, input bit dOn, input bit we,
                                 input logic [31:0] dA, input logic [31:0] wd, input logic [3:0] be,
                                 input int delay, input bit never,
                                 output int stallCycles, output int reqCycles,
                                 output logic [31:0] firstA, output logic [31:0] lastA);
        bit seen;
        @(posedge clk);
        #1;
        if_req = ifOn; if_addr = ifA;
        dm_req = dOn; dm_we = we; dm_addr = dA; dm_wdata = wd; dm_be = be;
        respDelay = delay; respNever = never;
        stallCycles = 0; reqCycles = 0; firstA = '1; lastA = '1; seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (mem_req) begin
                reqCycles++;
                if (!seen) firstA = mem_addr;
                seen = 1'b1;
                lastA = mem_addr;
            end
            if (!mem_stall) return;
            stallCycles++;
        end
        nChecks++;
        nFail++;
        $display("[TB] FAIL stall_bound: stall still high after %0d cycles, required release", stallCycles);
    endtask

    task automatic goIdle();
        @(posedge clk);
        #1;
        if_req = 1'b0;
        dm_req = 1'b0;
        respNever = 1'b0;
        respDelay = 0;
    endtask

    initial begin : stimulus
        int st, rq;
        logic [31:0] fa, la;
        bit reached;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_if_rdata", if_rdata, 32'd0);
        checkOutput("rst_stall", {31'b0, mem_stall}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] single fetch");
        applyStimulus(1, 32'h4, 0, 0, 0, 0, 4'h0, 0, 0, st, rq, fa, la);
        checkOutput("fetch_stall_cycles", st, 32'd2);
        checkOutput("fetch_addr", fa, 32'h4);
        checkOutput("fetch_rdata", if_rdata, 32'h0051_3023);
        applyStimulus(1, 32'h10, 0, 0, 0, 0, 4'h0, 0, 0, st, rq, fa, la);
        checkOutput("refetch_stall_cycles", st, 32'd2);
        checkOutput("refetch_rdata", if_rdata, 32'h5A5A_0010);

        $display("[TB] fetch and load together");
        applyStimulus(1, 32'h8, 1, 0, 32'h100, 0, 4'hF, 0, 0, st, rq, fa, la);
        checkOutput("both_stall_cycles", st, 32'd4);
        checkOutput("both_first_grant", fa, 32'h100);
        checkOutput("both_second_grant", la, 32'h8);
        checkOutput("both_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
        checkOutput("both_if_rdata", if_rdata, 32'h0000_0013);

        $display("[TB] slow store");
        applyStimulus(0, 0, 1, 1, 32'h200, 32'h1234_5678, 4'b0011, 4, 0, st, rq, fa, la);
        checkOutput("store_req_cycles", rq, 32'd5);
        checkOutput("store_stall_cycles", st, 32'd6);
        checkOutput("store_dm_rdata_kept", dm_rdata, 32'hDEAD_BEEF);

        $display("[TB] back-to-back loads with fetch");
        applyStimulus(1, 32'h20, 1, 0, 32'h100, 0, 4'hF, 0, 0, st, rq, fa, la);
        checkOutput("b2b1_stall_cycles", st, 32'd4);
        checkOutput("b2b1_fetch_between", la, 32'h20);
        applyStimulus(1, 32'h24, 1, 0, 32'h104, 0, 4'hF, 0, 0, st, rq, fa, la);
        checkOutput("b2b2_stall_cycles", st, 32'd4);
        checkOutput("b2b2_first_grant", fa, 32'h104);
        checkOutput("b2b2_fetch_between", la, 32'h24);
        checkOutput("b2b2_dm_rdata", dm_rdata, 32'hCAFE_F00D);
        checkOutput("b2b2_if_rdata", if_rdata, 32'h5A5A_0024);

        $display("[TB] fetch watchdog");
        applyStimulus(1, 32'h40, 0, 0, 0, 0, 4'h0, 0, 1, st, rq, fa, la);
        checkOutput("wd_req_cycles", rq, TO);
        checkOutput("wd_stall_cycles", st, TO + 1);
        checkOutput("wd_if_rdata", if_rdata, 32'h0);
        checkOutput("wd_err", {31'b0, err}, 32'd1);
        applyStimulus(1, 32'h4, 0, 0, 0, 0, 4'h0, 0, 0, st, rq, fa, la);
        checkOutput("wd_err_sticky", {31'b0, err}, 32'd1);
        checkOutput("wd_recover_rdata", if_rdata, 32'h0051_3023);

        $display("[TB] reset during data wait");
        goIdle();
        @(posedge clk);
        #1;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; dm_be = 4'hF; respNever = 1'b1;
        reached = 1'b0;
        for (int n = 0; n < 10 && !reached; n++) begin
            @(negedge clk);
            reached = mem_req;
        end
        checkOutput("rst_reached_wait", {31'b0, reached}, 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        dm_req = 1'b0;
        #1;
        checkOutput("arst_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("arst_mem_addr", mem_addr, 32'd0);
        checkOutput("arst_mem_be", {28'b0, mem_be}, 32'd0);
        checkOutput("arst_dm_rdata", dm_rdata, 32'd0);
        checkOutput("arst_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        respNever = 1'b0;
        injectStray = 1'b1;
        @(posedge clk);
        #1;
        injectStray = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("stray_dm_rdata", dm_rdata, 32'd0);
        checkOutput("stray_err", {31'b0, err}, 32'd0);
        checkOutput("stray_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("stray_stall", {31'b0, mem_stall}, 32'd0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin : globalWatchdog
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running, required completion");
        $fatal(1, "[TB] global timeout");
    end

endmodule
